// File: rtl/apb_uart_csr_if.sv
// rtl/apb_uart_csr_if.sv - APB bus bundle between the bridge and the UART register block
interface apb_uart_csr_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_uart_csr.sv
// rtl/apb_uart_csr.sv - APB register block for the UART with TX/RX byte FIFOs (option macro: UART_IRQ_EN)
module apb_uart_csr #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned WAIT_CYC   = 1,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    apb_uart_csr_if.slave apb,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [15:0]   baud_div
`ifdef UART_IRQ_EN
    ,
    output logic          irq
`endif
);
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned CW        = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [2:0]    WAIT_LAST = 3'(WAIT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_COMPLETE} state_t;

    state_t        state;
    logic [2:0]    wait_cnt;
    logic          pready, pslverr;
    logic [31:0]   prdata;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          tx_en, rx_en, rx_overrun;
    logic [15:0]   div_q;
`ifdef UART_IRQ_EN
    logic [2:0]    irq_mask;
    logic          irq_q;
`endif

    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic          tx_pop, tx_push, rx_push, rx_pop, rx_drop;
    logic          fire, acc_err, ctrl_we, div_we, mask_we, ovr_clr, tx_flush, rx_flush;
    logic [31:0]   acc_rdata, status;
    logic          unused_bits;

    function automatic logic [3:0] sat4(input logic [CW-1:0] c);
        logic [31:0] w;
        w = 32'(c);
        return (w > 32'd15) ? 4'hF : w[3:0];
    endfunction

    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == FULL_CNT);
    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);

    assign tx_valid = tx_en && !tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rptr];
    assign tx_pop   = tx_valid && tx_ready;

    // A byte arriving on a full RX FIFO still fits if a read pops in the same cycle.
    assign rx_push  = rx_valid && rx_en && (!rx_full || rx_pop);
    assign rx_drop  = rx_valid && rx_en && rx_full && !rx_pop;

    assign status = {19'b0, rx_overrun, rx_full, rx_empty, tx_full, tx_empty, sat4(rx_cnt), sat4(tx_cnt)};

    assign apb.PREADY  = pready;
    assign apb.PRDATA  = prdata;
    assign apb.PSLVERR = pslverr;
    assign baud_div    = div_q;
    assign unused_bits = ^{apb.PADDR[31:5], apb.PADDR[1:0], apb.PWDATA[31:16]};
`ifdef UART_IRQ_EN
    assign irq = irq_q;
`endif

    // Transfer completes on this edge: all register/FIFO side effects are tied to it.
    always_comb begin
        fire = 1'b0;
        if (apb.PSEL && apb.PENABLE) begin
            if (state == S_SETUP && WAIT_CYC == 0) fire = 1'b1;
            if (state == S_ACCESS && wait_cnt == WAIT_LAST) fire = 1'b1;
        end
    end

    // Address decode of the completing access into read data, error and side-effect strobes.
    always_comb begin
        acc_err   = 1'b0;
        acc_rdata = '0;
        tx_push   = 1'b0;
        rx_pop    = 1'b0;
        ctrl_we   = 1'b0;
        div_we    = 1'b0;
        mask_we   = 1'b0;
        ovr_clr   = 1'b0;
        tx_flush  = 1'b0;
        rx_flush  = 1'b0;
        if (fire) begin
            case (apb.PADDR[4:2])
                3'd0: begin
                    if (!apb.PWRITE)             acc_err = 1'b1;
                    else if (tx_full && !tx_pop) acc_err = 1'b1;
                    else                         tx_push = 1'b1;
                end
                3'd1: begin
                    if (apb.PWRITE || rx_empty) acc_err = 1'b1;
                    else begin
                        rx_pop    = 1'b1;
                        acc_rdata = {24'b0, rx_mem[rx_rptr]};
                    end
                end
                3'd2: begin
                    if (apb.PWRITE) ovr_clr   = apb.PWDATA[12];
                    else            acc_rdata = status;
                end
                3'd3: begin
                    if (apb.PWRITE) begin
                        ctrl_we  = 1'b1;
                        tx_flush = apb.PWDATA[2];
                        rx_flush = apb.PWDATA[3];
                    end else begin
                        acc_rdata = {30'b0, rx_en, tx_en};
                    end
                end
                3'd4: begin
                    if (apb.PWRITE) div_we    = 1'b1;
                    else            acc_rdata = {16'b0, div_q};
                end
`ifdef UART_IRQ_EN
                3'd5: begin
                    if (apb.PWRITE) mask_we   = 1'b1;
                    else            acc_rdata = {29'b0, irq_mask};
                end
`endif
                default: acc_err = 1'b1;
            endcase
        end
    end

    // APB handshake FSM with registered PREADY/PRDATA/PSLVERR.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            prdata   <= '0;
        end else begin
            pready  <= fire;
            pslverr <= fire && acc_err;
            prdata  <= fire ? acc_rdata : 32'h0;
            case (state)
                S_IDLE: begin
                    if (apb.PSEL && !apb.PENABLE) state <= S_SETUP;
                end
                S_SETUP: begin
                    if (!apb.PSEL) state <= S_IDLE;
                    else if (apb.PENABLE) begin
                        state    <= fire ? S_COMPLETE : S_ACCESS;
                        wait_cnt <= 3'd1;
                    end
                end
                S_ACCESS: begin
                    if (!apb.PSEL || !apb.PENABLE) state <= S_IDLE;
                    else if (fire)                 state <= S_COMPLETE;
                    else                           wait_cnt <= wait_cnt + 3'd1;
                end
                S_COMPLETE: state <= S_IDLE;
                default:    state <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers/counts and control registers; flush beats a same-cycle push.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            tx_wptr    <= '0;
            tx_rptr    <= '0;
            tx_cnt     <= '0;
            rx_wptr    <= '0;
            rx_rptr    <= '0;
            rx_cnt     <= '0;
            tx_en      <= 1'b0;
            rx_en      <= 1'b0;
            rx_overrun <= 1'b0;
            div_q      <= DIV_RESET;
        end else begin
            if (tx_flush) begin
                tx_wptr <= '0;
                tx_rptr <= '0;
                tx_cnt  <= '0;
            end else begin
                if (tx_push) tx_wptr <= tx_wptr + 1'b1;
                if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
                if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
                else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
            end
            if (rx_flush) begin
                rx_wptr <= '0;
                rx_rptr <= '0;
                rx_cnt  <= '0;
            end else begin
                if (rx_push) rx_wptr <= rx_wptr + 1'b1;
                if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
                if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
                else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
            end
            if (rx_drop && !rx_flush) rx_overrun <= 1'b1;
            else if (ovr_clr)         rx_overrun <= 1'b0;
            if (ctrl_we) begin
                tx_en <= apb.PWDATA[0];
                rx_en <= apb.PWDATA[1];
            end
            if (div_we) div_q <= apb.PWDATA[15:0];
        end
    end

    // FIFO storage; contents need no reset since empty FIFOs never expose them.
    always_ff @(posedge ACLK) begin
        if (tx_push) tx_mem[tx_wptr] <= apb.PWDATA[7:0];
        if (rx_push) rx_mem[rx_wptr] <= rx_data;
    end

`ifdef UART_IRQ_EN
    // Interrupt mask register and registered interrupt output.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            irq_mask <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (mask_we) irq_mask <= apb.PWDATA[2:0];
            irq_q <= (irq_mask[0] && !rx_empty) || (irq_mask[1] && tx_empty) ||
                     (irq_mask[2] && rx_overrun);
        end
    end
`endif
endmodule
